// File: rtl/fft_mag_stream_pkg.sv
// rtl/fft_mag_stream_pkg.sv - shared types and constants for the FFT magnitude stage
// Contents: FSM state enum, default widths, alpha-max-beta-min shift constants.
package fft_mag_stream_pkg;

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_IN_W   = 16;
  localparam int DEF_OUT_W  = 12;
  localparam int DEF_N_LOG2 = 10;

  // beta = 1/4 + 1/8 = 3/8
  localparam int MAG_BETA1_SH = 2;
  localparam int MAG_BETA2_SH = 3;

endpackage

// File: rtl/fft_mag_stream_if.sv
// rtl/fft_mag_stream_if.sv - bin input stream and magnitude write stream bundle
// master: drives s_re/s_im/s_valid/s_last, receives data/addr/valid/frame_done.
// slave : the magnitude stage side (receives bins, drives the write stream).
interface fft_mag_stream_if #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 12,
  parameter int N_LOG2 = 10
);
  logic [IN_W-1:0]   s_re;
  logic [IN_W-1:0]   s_im;
  logic              s_valid;
  logic              s_last;
  logic [OUT_W-1:0]  data;
  logic [N_LOG2-1:0] addr;
  logic              valid;
  logic              frame_done;

  modport master (
    output s_re, s_im, s_valid, s_last,
    input  data, addr, valid, frame_done
  );

  modport slave (
    input  s_re, s_im, s_valid, s_last,
    output data, addr, valid, frame_done
  );
endinterface

// File: rtl/fft_mag_stream_mag_approx.sv
// rtl/fft_mag_stream_mag_approx.sv - 3-stage abs / max-min / combine-scale-saturate datapath
// Ports: clk, rst (async, active-high); in_valid/in_re/in_im/in_addr/in_last in;
//        out_valid/out_data/out_addr/out_last registered out. addr/last ride as side-band.
// Option: FFT_MAG_DC_BLANK_EN forces data=0 for addr 0.
module mag_approx
  import fft_mag_stream_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int N_LOG2 = DEF_N_LOG2,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [IN_W-1:0]   in_re,
  input  logic [IN_W-1:0]   in_im,
  input  logic [N_LOG2-1:0] in_addr,
  input  logic              in_last,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [N_LOG2-1:0] out_addr,
  output logic              out_last
);

  localparam logic [IN_W:0] SAT_MAX = (IN_W+1)'((1 << OUT_W) - 1);

  logic [IN_W-1:0]   abs_re, abs_im;
  logic              v1, last1, v2, last2;
  logic [IN_W-1:0]   a1, b1, mx2, mn2;
  logic [N_LOG2-1:0] addr1, addr2;
  logic [IN_W:0]     mag, scaled;
  logic [OUT_W-1:0]  sat, dat;

  // Two's-complement negate in IN_W bits: the most negative value lands on
  // 2^(IN_W-1) as an unsigned number, which is exactly its magnitude.
  always_comb begin
    abs_re = in_re[IN_W-1] ? (~in_re + 1'b1) : in_re;
    abs_im = in_im[IN_W-1] ? (~in_im + 1'b1) : in_im;
  end

  always_comb begin
    mag    = {1'b0, mx2} + {1'b0, mn2 >> MAG_BETA1_SH} + {1'b0, mn2 >> MAG_BETA2_SH};
    scaled = mag >> SHIFT;
    sat    = (scaled > SAT_MAX) ? '1 : scaled[OUT_W-1:0];
`ifdef FFT_MAG_DC_BLANK_EN
    dat    = (addr2 == '0) ? '0 : sat;
`else
    dat    = sat;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; last1 <= 1'b0; a1 <= '0; b1 <= '0; addr1 <= '0;
      v2 <= 1'b0; last2 <= 1'b0; mx2 <= '0; mn2 <= '0; addr2 <= '0;
      out_valid <= 1'b0; out_last <= 1'b0; out_data <= '0; out_addr <= '0;
    end else begin
      v1    <= in_valid;
      last1 <= in_last;
      a1    <= abs_re;
      b1    <= abs_im;
      addr1 <= in_addr;

      v2    <= v1;
      last2 <= last1;
      mx2   <= (a1 >= b1) ? a1 : b1;
      mn2   <= (a1 >= b1) ? b1 : a1;
      addr2 <= addr1;

      out_valid <= v2;
      out_last  <= v2 & last2;
      // Bubbles leave data/addr holding the last written bin.
      if (v2) begin
        out_data <= dat;
        out_addr <= addr2;
      end
    end
  end

endmodule

// File: rtl/fft_mag_stream.sv
// rtl/fft_mag_stream.sv - streaming FFT bin magnitude stage with frame sync and length check
// Ports: clk, rst (async, active-high); st (fft_mag_stream_if.slave: s_re/s_im/s_valid/s_last in,
//        data/addr/valid/frame_done out); frame_err_clr in; frame_err out (sticky).
// Option: FFT_MAG_DC_BLANK_EN (applied in mag_approx) blanks bin 0.
module fft_mag_stream
  import fft_mag_stream_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int N_LOG2 = DEF_N_LOG2,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  fft_mag_stream_if.slave   st,
  input  logic              frame_err_clr,
  output logic              frame_err
);

  localparam logic [N_LOG2-1:0] BIN_MAX = '1;

  state_t            state, state_nx;
  logic [N_LOG2-1:0] bin, bin_nx;
  logic              accept, err_set, tag_last;

  always_comb begin
    state_nx = state;
    bin_nx   = bin;
    accept   = 1'b0;
    err_set  = 1'b0;
    tag_last = 1'b0;
    case (state)
      SYNC: begin
        bin_nx = '0;
        // The aligning s_last sample itself is discarded.
        if (st.s_valid && st.s_last) state_nx = RUN;
      end
      RUN: begin
        if (st.s_valid) begin
          accept = 1'b1;
          if (st.s_last) begin
            tag_last = 1'b1;
            err_set  = (bin != BIN_MAX);
            bin_nx   = '0;
          end else if (bin == BIN_MAX) begin
            // Frame overran: keep this bin, then drop until the next s_last.
            err_set  = 1'b1;
            bin_nx   = '0;
            state_nx = SYNC;
          end else begin
            bin_nx = bin + 1'b1;
          end
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SYNC;
      bin       <= '0;
      frame_err <= 1'b0;
    end else begin
      state <= state_nx;
      bin   <= bin_nx;
      if (err_set)            frame_err <= 1'b1;
      else if (frame_err_clr) frame_err <= 1'b0;
    end
  end

  mag_approx #(
    .IN_W(IN_W), .OUT_W(OUT_W), .N_LOG2(N_LOG2), .SHIFT(SHIFT)
  ) u_mag (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .in_re     (st.s_re),
    .in_im     (st.s_im),
    .in_addr   (bin),
    .in_last   (tag_last),
    .out_valid (st.valid),
    .out_data  (st.data),
    .out_addr  (st.addr),
    .out_last  (st.frame_done)
  );

endmodule

// File: tb/tb_fft_mag_stream.sv
// tb/tb_fft_mag_stream.sv - randomized self-checking bench for fft_mag_stream (SHIFT=4 and SHIFT=2)
module tb_fft_mag_stream;

  localparam int NB = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_err_clr = 1'b0;
  logic frame_err4, frame_err2;

  always #5 clk = ~clk;

  fft_mag_stream_if #(.IN_W(16), .OUT_W(12), .N_LOG2(10)) if4 ();
  fft_mag_stream_if #(.IN_W(16), .OUT_W(12), .N_LOG2(10)) if2 ();

  assign if2.s_re    = if4.s_re;
  assign if2.s_im    = if4.s_im;
  assign if2.s_valid = if4.s_valid;
  assign if2.s_last  = if4.s_last;

  fft_mag_stream #(.IN_W(16), .OUT_W(12), .N_LOG2(10), .SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .st(if4.slave),
    .frame_err_clr(frame_err_clr), .frame_err(frame_err4)
  );

  fft_mag_stream #(.IN_W(16), .OUT_W(12), .N_LOG2(10), .SHIFT(2)) dut2 (
    .clk(clk), .rst(rst), .st(if2.slave),
    .frame_err_clr(frame_err_clr), .frame_err(frame_err2)
  );

  typedef struct {
    bit v;
    bit last;
    int addr;
    int d4;
    int d2;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   m_run = 0;
  int   m_bin = 0;
  bit   m_err = 0;
  int   h4 = 0, h2 = 0, ha = 0;
  int   vcnt = 0, dcnt = 0, daddr = -1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_mag(input int re, input int im, input int sh, input int addr);
    int a, b, mx, mn, m, d;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    m  = mx + mn / 4 + mn / 8;
    d  = m / (1 << sh);
    if (d > 4095) d = 4095;
`ifdef FFT_MAG_DC_BLANK_EN
    if (addr == 0) d = 0;
`else
    if (addr < 0) d = 0;
`endif
    return d;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic step(input bit v, input bit last, input int re, input int im, input bit clr);
    exp_t e;
    bit   err_now;
    @(negedge clk);
    if4.s_valid   = v;
    if4.s_last    = last;
    if4.s_re      = re[15:0];
    if4.s_im      = im[15:0];
    frame_err_clr = clr;
    e = '{v: 1'b0, last: 1'b0, addr: 0, d4: 0, d2: 0};
    err_now = 0;
    if (v) begin
      if (!m_run) begin
        if (last) m_run = 1;
      end else begin
        e.v    = 1;
        e.last = last;
        e.addr = m_bin;
        e.d4   = ref_mag(re, im, 4, m_bin);
        e.d2   = ref_mag(re, im, 2, m_bin);
        if (last) begin
          if (m_bin != NB - 1) err_now = 1;
          m_bin = 0;
        end else if (m_bin == NB - 1) begin
          err_now = 1;
          m_bin   = 0;
          m_run   = 0;
        end else begin
          m_bin++;
        end
      end
    end
    if (err_now) m_err = 1;
    else if (clr) m_err = 0;
    q.push_back(e);
    @(posedge clk);
    #1;
    check("frame_err_s4", int'(frame_err4), int'(m_err));
    check("frame_err_s2", int'(frame_err2), int'(m_err));
    if (q.size() == 3) begin
      e = q.pop_front();
      if (e.v) begin
        h4 = e.d4;
        h2 = e.d2;
        ha = e.addr;
      end
      check("valid_s4", int'(if4.valid), int'(e.v));
      check("valid_s2", int'(if2.valid), int'(e.v));
      check("done_s4", int'(if4.frame_done), int'(e.v && e.last));
      check("done_s2", int'(if2.frame_done), int'(e.v && e.last));
      check("data_s4", int'(if4.data), h4);
      check("data_s2", int'(if2.data), h2);
      check("addr_s4", int'(if4.addr), ha);
      check("addr_s2", int'(if2.addr), ha);
      if (if4.valid) vcnt++;
      if (if4.frame_done) begin
        dcnt++;
        daddr = int'(if4.addr);
      end
    end
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    exp_t b;
    @(negedge clk);
    rst           = 1'b1;
    if4.s_valid   = 1'b0;
    if4.s_last    = 1'b0;
    frame_err_clr = 1'b0;
    #1;
    check("rst_data", int'(if4.data), 0);
    check("rst_addr", int'(if4.addr), 0);
    check("rst_valid", int'(if4.valid) + int'(if2.valid), 0);
    check("rst_done", int'(if4.frame_done) + int'(if2.frame_done), 0);
    check("rst_err", int'(frame_err4) + int'(frame_err2), 0);
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_run = 0;
    m_bin = 0;
    m_err = 0;
    h4 = 0; h2 = 0; ha = 0;
    q.delete();
    b = '{v: 1'b0, last: 1'b0, addr: 0, d4: 0, d2: 0};
    q.push_back(b);
    q.push_back(b);
  endtask

  initial begin
    int exp_v;
    if4.s_re    = '0;
    if4.s_im    = '0;
    if4.s_valid = 1'b0;
    if4.s_last  = 1'b0;

    do_reset();
    bubbles(3);

    // Sync, then one full frame of re=1000, im=0.
    vcnt = 0; dcnt = 0; daddr = -1;
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < NB; i++) step(1, (i == NB - 1), 1000, 0, 0);
    bubbles(2);
    check("frame1_valid_cnt", vcnt, NB);
    check("frame1_done_cnt", dcnt, 1);
    check("frame1_done_addr", daddr, NB - 1);

    // Keep the directed magnitude probes off bin 0.
    step(1, 0, 1, 1, 0);
    step(1, 0, -3000, 4000, 0);
    bubbles(3);
    check("mixed_s4", int'(if4.data), 320);
    check("mixed_s2", int'(if2.data), 1281);
    step(1, 0, -32768, -32768, 0);
    bubbles(3);
    check("sat_neg_s2", int'(if2.data), 4095);
    check("sat_neg_s4", int'(if4.data), 2816);
    step(1, 0, 32767, 0, 0);
    bubbles(3);
    check("sat_pos_s2", int'(if2.data), 4095);

    // Early s_last at bin 500.
    for (int i = 0; i < 1100 && m_bin != 500; i++) step(1, 0, rnd16(), rnd16(), 0);
    dcnt = 0;
    step(1, 1, rnd16(), rnd16(), 0);
    check("early_err", int'(frame_err4), 1);
    bubbles(2);
    check("early_done_cnt", dcnt, 1);
    check("early_done_addr", daddr, 500);
    step(1, 0, 700, 0, 0);
    bubbles(2);
    check("after_early_addr", int'(if4.addr), 0);
    step(0, 0, 0, 0, 1);
    check("err_clr", int'(frame_err4), 0);

    // Missing s_last: frame overruns, samples past bin max are dropped.
    exp_v = NB - m_bin;
    vcnt  = 0;
    for (int i = 0; i < 1030; i++) step(1, 0, rnd16(), rnd16(), 0);
    bubbles(2);
    check("missing_valid_cnt", vcnt, exp_v);
    check("missing_err", int'(frame_err4), 1);
    step(1, 1, 0, 0, 0);
    step(1, 0, 1000, 0, 0);
    bubbles(2);
    check("resync_addr", int'(if4.addr), 0);

    // Random traffic: bubbles, mostly well-formed frames, occasional bad lengths and clears.
    for (int i = 0; i < 3000; i++) begin
      bit v, l, c;
      v = ($urandom_range(0, 9) < 8);
      if (m_run && m_bin == NB - 1) l = ($urandom_range(0, 9) < 8);
      else l = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 49) == 0);
      step(v, l, rnd16(), rnd16(), c);
    end

    // Reset in the middle of a frame.
    for (int i = 0; i < 3000 && !(m_run && m_bin == 300); i++)
      step(1, !m_run, rnd16(), rnd16(), 0);
    if (!(m_run && m_bin == 300)) check("reach_bin300_timeout", 0, 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, rnd16(), rnd16(), 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 2000, 0, 0);
    bubbles(3);
`ifdef FFT_MAG_DC_BLANK_EN
    check("dc_bin_data", int'(if4.data), 0);
`else
    check("dc_bin_data", int'(if4.data), 125);
`endif
    check("dc_bin_addr", int'(if4.addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fft_mag_stream.md
# fft_mag_stream

Streaming magnitude stage between the FFT core output and the harmonic/THD measurement block. It takes one complex FFT bin per cycle (signed real/imag), computes an alpha-max-beta-min magnitude, scales and saturates it to 12 bits, and tags it with its bin index. It emits the `data`/`addr`/`valid` write stream that the THD stage stores into its spectrum buffer. It also aligns to frame boundaries and flags malformed frames.

## Interface
- `IN_W`, 16, width of signed real/imag input
- `OUT_W`, 12, width of unsigned magnitude output
- `N_LOG2`, 10, log2 of FFT length (bins per frame = 2^N_LOG2)
- `SHIFT`, 4, right shift applied to the raw magnitude before saturation
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `s_re`  in  IN_W  signed real part of current bin
- `s_im`  in  IN_W  signed imaginary part of current bin
- `s_valid`  in  1  input sample valid; there is no backpressure, so every valid sample is accepted
- `s_last`  in  1  qualifies the final bin of an FFT frame (meaningful only with `s_valid`)
- `frame_err_clr`  in  1  single-cycle clear of `frame_err`
- `data`  out  OUT_W  scaled magnitude
- `addr`  out  N_LOG2  bin index of `data`
- `valid`  out  1  `data`/`addr` valid
- `frame_done`  out  1  one-cycle pulse coincident with the output of a frame's last bin
- `frame_err`  out  1  sticky: frame length ≠ 2^N_LOG2 detected

## Operation
- **FSM states:**
  - SYNC (reset state): samples are discarded and the bin counter is held at 0. A valid sample with `s_last` moves the FSM to RUN; that sample itself is discarded.
  - RUN: each valid sample is accepted and enters the pipeline with tag `bin`. `bin` then increments.
- **Frame length checking in RUN:**
  - Correct frame: `s_last` arrives with `bin` = 2^N_LOG2−1. `bin` returns to 0 and `frame_done` is raised for that sample.
  - Early `s_last` (`bin` < max): `frame_err` is set, `frame_done` still pulses for that sample, and `bin` returns to 0.
  - Missing `s_last` at `bin` = max: `frame_err` is set, `bin` wraps to 0, no `frame_done` is raised, and the FSM returns to SYNC. Subsequent samples are dropped until the next `s_last`.
- **Magnitude arithmetic:**
  - a = |s_re|, b = |s_im|, each IN_W-bit unsigned. −2^(IN_W−1) maps to 2^(IN_W−1) exactly.
  - mx = max(a,b), mn = min(a,b).
  - mag = mx + (mn>>2) + (mn>>3), in IN_W+1 bits. This approximates max + 3/8·min; peak error ≤ 7 %.
  - data = min((mag>>SHIFT), 2^OUT_W−1). Saturation is silent.
- `frame_err` clears only on `frame_err_clr` or reset. If `frame_err_clr` and a new error occur in the same cycle, the error wins.
- **Reset values:** `data`=0, `addr`=0, `valid`=0, `frame_done`=0, `frame_err`=0. All pipeline valid bits are 0, the FSM is in SYNC, and `bin`=0. A reset mid-frame discards in-flight samples, and the block must resynchronise on the next `s_last`.

## Timing
- Three-stage pipeline with a fixed latency of 3 cycles from accepted input to `valid`:
  - S1: abs.
  - S2: max/min.
  - S3: combine, shift, saturate. Outputs are registered.
- `addr`, `frame_done`, and the sample's valid bit travel alongside data through all three stages.
- Full throughput: one bin per cycle sustained, with bubbles allowed anywhere. A bubble produces `valid`=0 three cycles later, and `addr`/`data` hold their previous values.
- `frame_err` updates one cycle after the offending input sample, not pipeline-delayed.
- The SYNC→RUN transition takes effect on the cycle after the `s_last` sample. A valid sample in the very next cycle is accepted as bin 0.

## Configuration
- `FFT_MAG_DC_BLANK_EN`:
  - Defined: the output for `addr`=0 is forced to `data`=0, with `valid` unchanged. This prevents DC from being picked as the fundamental downstream.
  - Undefined: bin 0 is processed like every other bin.

## Structure
- A shared package holds:
  - the FSM state enum (SYNC, RUN);
  - the default widths IN_W/OUT_W/N_LOG2;
  - the constants MAG_BETA1_SH=2 and MAG_BETA2_SH=3.
- One sub-module, `mag_approx`: the pure S1–S3 datapath, carrying a tag side-band of addr and last. The parent holds the FSM, bin counter, and error logic.

## Test plan
- **Basic magnitude and framing:** SHIFT=4; after a sync `s_last`, stream 1024 bins with re=1000, im=0. Expect `data`=62 for addr 0..1023, `valid` 3 cycles after each input, and a single `frame_done` with addr=1023.
- **Mixed signs:** re=−3000, im=4000. Expect mag=5125 and `data`=320.
- **Saturation:** SHIFT=2, re=im=−32768. Expect raw 45056 → `data`=4095. Separately, re=32767, im=0 gives `data`=8191→4095.
- **Frame length errors:**
  - Early `s_last` at bin 500: `frame_err`=1 next cycle, `frame_done` with addr=500, and the next sample gets addr=0.
  - `frame_err_clr` clears the flag.
- **Missing `s_last` and resync:** drive 1030 samples with no `s_last`. Expect `frame_err`=1, the FSM in SYNC, no `valid` for samples 1024..1029, and resumption at addr 0 after the next `s_last`.
- **Reset mid-frame:**
  - Assert `rst` at bin 300: all outputs go to 0 immediately and no stale `valid` appears.
  - Samples after deassertion are dropped until `s_last`.
  - With `FFT_MAG_DC_BLANK_EN` defined, bin 0 with re=2000 outputs `data`=0.
